// File: rtl/dtc_phase_sequencer.sv
// Phase sequencer for the DTC front end: plays one-hot, guarded phase pulses
// d[N_PHASE-1:0] from a configuration latched when a start request is accepted.
module dtc_phase_sequencer #(
    parameter int N_PHASE = 4,
    parameter int DWELL_W = 8,
    parameter int REP_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [N_PHASE-1:0]         cfg_mask,
    input  logic [DWELL_W-1:0]         cfg_dwell,
    input  logic [REP_W-1:0]           cfg_reps,
    output logic [N_PHASE-1:0]         d,
    output logic [$clog2(N_PHASE)-1:0] phase_idx,
    output logic [REP_W-1:0]           pass_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int IDX_W = $clog2(N_PHASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_DRIVE,
        S_GAP,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [N_PHASE-1:0]   r_mask;
    logic [DWELL_W-1:0]   r_dwell;
    logic [REP_W-1:0]     r_reps;
    logic [DWELL_W-1:0]   r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [REP_W-1:0]     r_pass;
    logic [N_PHASE-1:0]   r_d;
    logic [IDX_W-1:0]     r_phase_idx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    state_t               w_state_next;
    logic [N_PHASE-1:0]   w_mask_next;
    logic [DWELL_W-1:0]   w_dwell_next;
    logic [REP_W-1:0]     w_reps_next;
    logic [DWELL_W-1:0]   w_cnt_next;
    logic [IDX_W-1:0]     w_idx_next;
    logic [REP_W-1:0]     w_pass_next;
    logic [N_PHASE-1:0]   w_d_next;
    logic                 w_err_next;
    logic [IDX_W-1:0]     w_lo_idx;
    logic [IDX_W-1:0]     w_hi_idx;
    logic                 w_hi_found;

    // Lowest enabled phase, and lowest enabled phase above the current one.
    always_comb begin
        w_lo_idx   = '0;
        w_hi_idx   = '0;
        w_hi_found = 1'b0;
        for (int k = N_PHASE - 1; k >= 0; k--) begin
            if (r_mask[k]) begin
                w_lo_idx = IDX_W'(k);
                if (k > int'(r_idx)) begin
                    w_hi_idx   = IDX_W'(k);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_dwell_next = r_dwell;
        w_reps_next  = r_reps;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_pass_next  = r_pass;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (|cfg_mask) begin
                        w_mask_next  = cfg_mask;
                        w_dwell_next = cfg_dwell;
                        w_reps_next  = cfg_reps;
                        w_pass_next  = '0;
                        w_state_next = S_SETTLE;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                w_idx_next   = w_lo_idx;
                w_cnt_next   = r_dwell;
                w_state_next = S_DRIVE;
            end
            S_DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_next = S_GAP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (w_hi_found) begin
                    w_idx_next   = w_hi_idx;
                    w_cnt_next   = r_dwell;
                    w_state_next = S_DRIVE;
                end else if (r_pass < r_reps) begin
                    w_pass_next  = r_pass + 1'b1;
                    w_idx_next   = w_lo_idx;
                    w_cnt_next   = r_dwell;
                    w_state_next = S_DRIVE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Abort drops everything back to the reset picture, including latched config.
        if (abort && r_state != S_IDLE) begin
            w_state_next = S_IDLE;
            w_mask_next  = '0;
            w_dwell_next = '0;
            w_reps_next  = '0;
            w_cnt_next   = '0;
        end
        if (w_state_next == S_IDLE) begin
            w_idx_next  = '0;
            w_pass_next = '0;
        end

        w_d_next = '0;
        if (w_state_next == S_DRIVE) begin
            w_d_next[w_idx_next] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_dwell     <= '0;
            r_reps      <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pass      <= '0;
            r_d         <= '0;
            r_phase_idx <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mask      <= w_mask_next;
            r_dwell     <= w_dwell_next;
            r_reps      <= w_reps_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_pass      <= w_pass_next;
            r_d         <= w_d_next;
            r_phase_idx <= (w_state_next == S_DRIVE) ? w_idx_next : '0;
            r_busy      <= (w_state_next == S_SETTLE) || (w_state_next == S_DRIVE) ||
                           (w_state_next == S_GAP);
            r_done      <= (w_state_next == S_DONE);
            r_err       <= w_err_next;
        end
    end

    assign d         = r_d;
    assign phase_idx = r_phase_idx;
    assign pass_cnt  = r_pass;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_dtc_phase_sequencer.sv
// Directed bench for dtc_phase_sequencer: hand-computed cycle vectors, abort,
// async reset, held start with config changes, and a continuous one-hot check.
module tb_dtc_phase_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] cfg_mask;
    logic [7:0] cfg_dwell;
    logic [3:0] cfg_reps;
    logic [3:0] d;
    logic [1:0] phase_idx;
    logic [3:0] pass_cnt;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    dtc_phase_sequencer #(.N_PHASE(4), .DWELL_W(8), .REP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_mask(cfg_mask), .cfg_dwell(cfg_dwell), .cfg_reps(cfg_reps),
        .d(d), .phase_idx(phase_idx), .pass_cnt(pass_cnt),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) chk("onehot", 32'($countones(d) <= 1), 32'd1);
    end

    // Presents a one-cycle start; returns at the negedge of the SETTLE cycle.
    task automatic kick(input logic [3:0] m, input logic [7:0] dw, input logic [3:0] rp);
        cfg_mask  = m;
        cfg_dwell = dw;
        cfg_reps  = rp;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Counts busy cycles from the current negedge; ends on the cycle after busy.
    task automatic measure(output int nbusy, output logic [3:0] d_or);
        nbusy = 0;
        d_or  = '0;
        while (busy === 1'b1 && nbusy < 400) begin
            nbusy++;
            d_or = d_or | d;
            @(negedge clk);
        end
    endtask

    logic [3:0] exp1_d [17] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                                4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};
    logic [3:0] exp2_d [9]  = '{4'h0, 4'h2, 4'h0, 4'h8, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0};
    logic [3:0] exp2_p [9]  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
    logic [1:0] exp2_i [9]  = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0};

    initial begin
        int         nb;
        logic [3:0] dor;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_mask = '0; cfg_dwell = '0; cfg_reps = '0;
        repeat (2) @(negedge clk);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pass", 32'(pass_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_err", 32'(err), 32'd0);

        // 1: all four phases, 3-cycle dwell, single pass
        kick(4'hF, 8'd2, 4'd0);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("t1_d[%0d]", i), 32'(d), 32'(exp1_d[i]));
            chk($sformatf("t1_busy[%0d]", i), 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);
        $display("t1 mask=F dwell=2 reps=0 checked");

        // 2: sparse mask, 1-cycle dwell, two passes
        kick(4'hA, 8'd0, 4'd1);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t2_d[%0d]", i), 32'(d), 32'(exp2_d[i]));
            chk($sformatf("t2_pass[%0d]", i), 32'(pass_cnt), 32'(exp2_p[i]));
            chk($sformatf("t2_idx[%0d]", i), 32'(phase_idx), 32'(exp2_i[i]));
            chk($sformatf("t2_busy[%0d]", i), 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("t2_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("t2_done_pulse", 32'(done), 32'd0);
        chk("t2_pass_idle", 32'(pass_cnt), 32'd0);
        $display("t2 mask=A dwell=0 reps=1 checked");

        // 3: empty mask raises err only
        kick(4'h0, 8'd3, 4'd0);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_d", 32'(d), 32'd0);
        @(negedge clk);
        chk("t3_err_pulse", 32'(err), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        $display("t3 mask=0 err checked");

        // 4: abort on the third DRIVE cycle, then a clean restart
        kick(4'h4, 8'd5, 4'd0);
        repeat (3) @(negedge clk);
        chk("t4_d_pre", 32'(d), 32'h4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_d", 32'(d), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("t4_done2", 32'(done), 32'd0);
        kick(4'h4, 8'd5, 4'd0);
        measure(nb, dor);
        chk("t4_rerun_busy", 32'(nb), 32'd8);
        chk("t4_rerun_dor", 32'(dor), 32'h4);
        chk("t4_rerun_done", 32'(done), 32'd1);
        @(negedge clk);
        $display("t4 abort mid-DRIVE checked");

        // 5: asynchronous reset mid-DRIVE
        kick(4'hF, 8'd10, 4'd0);
        repeat (3) @(negedge clk);
        chk("t5_d_pre", 32'(d), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t5_d_async", 32'(d), 32'd0);
        chk("t5_busy_async", 32'(busy), 32'd0);
        chk("t5_pass_async", 32'(pass_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_d", 32'(d), 32'd0);
        $display("t5 async reset checked");

        // 6: start held high, cfg changes mid-run, back-to-back restart
        cfg_mask = 4'h1; cfg_dwell = 8'd1; cfg_reps = 4'd0; start = 1'b1;
        @(negedge clk);
        cfg_mask = 4'hF;
        measure(nb, dor);
        chk("t6_run1_busy", 32'(nb), 32'd4);
        chk("t6_run1_dor", 32'(dor), 32'h1);
        chk("t6_run1_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("t6_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t6_run2_start", 32'(busy), 32'd1);
        start = 1'b0;
        measure(nb, dor);
        chk("t6_run2_busy", 32'(nb), 32'd13);
        chk("t6_run2_dor", 32'(dor), 32'hF);
        chk("t6_run2_done", 32'(done), 32'd1);
        @(negedge clk);
        $display("t6 held start / cfg latch checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
